gate_identifier: RTL and testbench
==================================

GATE_IDENTIFIER -- requirements
Module: gate_identifier

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 2, number of wait cycles after each new stimulus before sampling; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a new identification run; sampled only in IDLE.
REQ-005 SHALL have port: probe_y  input  1  response of the two-input gate under test.
REQ-006 SHALL have port: drv_a  output  1  stimulus input a to the gate under test, registered.
REQ-007 SHALL have port: drv_b  output  1  stimulus input b to the gate under test, registered.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when results update.
REQ-010 SHALL have port: truth_table  output  4  captured response; bit index = {a,b}.
REQ-011 SHALL have port: gate_code  output  3  0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR 7=unknown.
REQ-012 SHALL have port: valid  output  1  high when gate_code is 0..5.
REQ-013 SHALL have port: unstable  output  1  response-mismatch flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE: start=1 SHALL move to SETTLE with vector index 0, drv_a=0, drv_b=0, settle counter cleared.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-017 SAMPLE SHALL store probe_y into an internal capture bit [index] for one cycle.
REQ-018 After SAMPLE with index<3, the FSM SHALL increment index, drive {drv_a,drv_b}=index, and return to SETTLE.
REQ-019 After SAMPLE with index=3, the FSM SHALL move to DONE.
REQ-020 Vector order SHALL be {a,b} = 00, 01, 10, 11.
REQ-021 DONE SHALL last one cycle and SHALL assert done; the cycle after, truth_table, gate_code and valid SHALL present the new result, and the FSM SHALL return to IDLE.
REQ-022 Decode (truth_table[3:0]) SHALL be: 1000=AND, 1110=OR, 0111=NAND, 0001=NOR, 0110=XOR, 1001=XNOR.
REQ-023 Any other truth_table value SHALL give gate_code=7 and valid=0.
REQ-024 Latency from the start-accept edge to the done pulse SHALL be 4*(SETTLE_CYCLES+1)+1 cycles; with the default this is 13.
REQ-025 busy SHALL be high in SETTLE, SAMPLE and DONE, and low in IDLE.
REQ-026 start SHALL be ignored whenever busy=1, including the DONE cycle.
REQ-027 truth_table, gate_code, valid and unstable SHALL hold their previous values until the next done.
REQ-028 drv_a and drv_b SHALL return to 0 in DONE and IDLE.

Reset
REQ-029 rst=1 SHALL override every other input in the same cycle, including a simultaneous start.
REQ-030 Reset SHALL force: state IDLE, index 0, counter 0, drv_a=0, drv_b=0, busy=0, done=0, truth_table=0000, gate_code=7, valid=0, unstable=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no done pulse, and SHALL discard partial captures.

Configuration
REQ-032 Macro GATE_ID_REPEAT_EN SHALL control double sampling.
REQ-033 When GATE_ID_REPEAT_EN is defined, SAMPLE SHALL last 2 cycles per vector.
REQ-034 When GATE_ID_REPEAT_EN is defined, the second sample SHALL be stored.
REQ-035 When GATE_ID_REPEAT_EN is defined, any mismatch between the two samples in a run SHALL set unstable=1 and force valid=0, gate_code=7 at done.
REQ-036 When GATE_ID_REPEAT_EN is defined, latency SHALL become 4*(SETTLE_CYCLES+2)+1 cycles.
REQ-037 When GATE_ID_REPEAT_EN is undefined, unstable SHALL be tied to 0 and single-sample behaviour SHALL apply.

Verification
REQ-038 Scenario 1: model an XOR gate on probe_y, pulse start -> done at cycle 13, truth_table=0110, gate_code=4, valid=1.
REQ-039 Scenario 2: sweep AND, OR, NAND, NOR and XNOR models -> gate_code=0, 1, 2, 3, 5 respectively, all with valid=1.
REQ-040 Scenario 3: tie probe_y=1 -> truth_table=1111, gate_code=7, valid=0.
REQ-041 Scenario 4: pulse start again at cycles 3 and 12 of a run -> no restart, exactly one done pulse, latency still 13.
REQ-042 Scenario 5: assert rst at cycle 6 of an AND run -> next cycle all outputs at reset values, no done; a fresh start then identifies AND normally.
REQ-043 Scenario 6 (GATE_ID_REPEAT_EN): toggle probe_y between the two samples of vector 10 on an OR model -> unstable=1, valid=0, gate_code=7, done at cycle 17.

Source files
------------

// File: rtl/gate_identifier.sv
// gate_identifier
// ---------------------------------------------------------------------------
// Identifies an unknown two-input logic gate by driving the four input
// vectors {a,b} = 00, 01, 10, 11 in turn, waiting SETTLE_CYCLES after each
// change, sampling the gate response and decoding the captured truth table.
//
// Parameters
//   SETTLE_CYCLES  wait cycles after each new stimulus (legal 1..15)
//
// Optional feature
//   GATE_ID_REPEAT_EN  when defined, every vector is sampled twice on two
//                      consecutive cycles. The second sample is stored, and
//                      any disagreement in a run raises 'unstable' and forces
//                      an unknown result.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin an identification run (only honoured when idle)
//   probe_y      in   response of the gate under test
//   drv_a/drv_b  out  registered stimulus to the gate under test
//   busy         out  high while a run is in progress (SETTLE/SAMPLE/DONE)
//   done         out  one-cycle pulse; results change on the following cycle
//   truth_table  out  captured response, bit index = {a,b}
//   gate_code    out  0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR 7=unknown
//   valid        out  gate_code is a recognised gate
//   unstable     out  samples disagreed during the last run (repeat mode)
//
// Handshake: start is a level sampled on the rising edge while busy is low;
// the run is accepted on that edge and busy rises on the next cycle. start
// is ignored while busy is high, including the DONE cycle.
// ---------------------------------------------------------------------------
module gate_identifier #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       probe_y,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_code,
    output logic       valid,
    output logic       unstable
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] CODE_UNKNOWN = 3'd7;

    state_t     state_q, state_d;
    logic [1:0] index_q, index_d;
    logic [3:0] cnt_q, cnt_d;
    logic       drv_a_q, drv_a_d;
    logic       drv_b_q, drv_b_d;
    logic [3:0] capture_q, capture_d;
    logic [3:0] truth_table_q, truth_table_d;
    logic [2:0] gate_code_q, gate_code_d;
    logic       valid_q, valid_d;

    // High on the SAMPLE cycle that stores the bit and advances the vector.
    logic       sample_last;

`ifdef GATE_ID_REPEAT_EN
    logic       phase_q, phase_d;        // 0 = first sample, 1 = second
    logic       first_q, first_d;        // first sample of current vector
    logic       mismatch_q, mismatch_d;  // sticky disagreement within run
    logic       unstable_q, unstable_d;

    assign sample_last = phase_q;
    assign unstable    = unstable_q;
`else
    assign sample_last = 1'b1;
    assign unstable    = 1'b0;
`endif

    function automatic logic [2:0] decode(input logic [3:0] tt);
        case (tt)
            4'b1000: decode = 3'd0;  // AND
            4'b1110: decode = 3'd1;  // OR
            4'b0111: decode = 3'd2;  // NAND
            4'b0001: decode = 3'd3;  // NOR
            4'b0110: decode = 3'd4;  // XOR
            4'b1001: decode = 3'd5;  // XNOR
            default: decode = CODE_UNKNOWN;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        cnt_d         = cnt_q;
        drv_a_d       = drv_a_q;
        drv_b_d       = drv_b_q;
        capture_d     = capture_q;
        truth_table_d = truth_table_q;
        gate_code_d   = gate_code_q;
        valid_d       = valid_q;
`ifdef GATE_ID_REPEAT_EN
        phase_d       = phase_q;
        first_d       = first_q;
        mismatch_d    = mismatch_q;
        unstable_d    = unstable_q;
`endif

        case (state_q)
            ST_IDLE: begin
                drv_a_d = 1'b0;
                drv_b_d = 1'b0;
                if (start) begin
                    state_d   = ST_SETTLE;
                    index_d   = 2'd0;
                    cnt_d     = 4'd0;
                    capture_d = 4'd0;
`ifdef GATE_ID_REPEAT_EN
                    phase_d    = 1'b0;
                    mismatch_d = 1'b0;
`endif
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_SAMPLE: begin
`ifdef GATE_ID_REPEAT_EN
                if (!phase_q) begin
                    first_d = probe_y;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (probe_y != first_q) begin
                        mismatch_d = 1'b1;
                    end
                end
`endif
                if (sample_last) begin
                    capture_d[index_q] = probe_y;
                    if (index_q == 2'd3) begin
                        state_d = ST_DONE;
                        index_d = 2'd0;
                        drv_a_d = 1'b0;
                        drv_b_d = 1'b0;
                    end else begin
                        state_d              = ST_SETTLE;
                        index_d              = index_q + 2'd1;
                        {drv_a_d, drv_b_d}   = index_q + 2'd1;
                    end
                end
            end

            ST_DONE: begin
                state_d       = ST_IDLE;
                truth_table_d = capture_q;
                gate_code_d   = decode(capture_q);
`ifdef GATE_ID_REPEAT_EN
                unstable_d = mismatch_q;
                if (mismatch_q) begin
                    gate_code_d = CODE_UNKNOWN;
                end
`endif
                valid_d = (gate_code_d != CODE_UNKNOWN);
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            index_q       <= 2'd0;
            cnt_q         <= 4'd0;
            drv_a_q       <= 1'b0;
            drv_b_q       <= 1'b0;
            capture_q     <= 4'd0;
            truth_table_q <= 4'd0;
            gate_code_q   <= CODE_UNKNOWN;
            valid_q       <= 1'b0;
`ifdef GATE_ID_REPEAT_EN
            phase_q       <= 1'b0;
            first_q       <= 1'b0;
            mismatch_q    <= 1'b0;
            unstable_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            cnt_q         <= cnt_d;
            drv_a_q       <= drv_a_d;
            drv_b_q       <= drv_b_d;
            capture_q     <= capture_d;
            truth_table_q <= truth_table_d;
            gate_code_q   <= gate_code_d;
            valid_q       <= valid_d;
`ifdef GATE_ID_REPEAT_EN
            phase_q       <= phase_d;
            first_q       <= first_d;
            mismatch_q    <= mismatch_d;
            unstable_q    <= unstable_d;
`endif
        end
    end

    assign drv_a       = drv_a_q;
    assign drv_b       = drv_b_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign truth_table = truth_table_q;
    assign gate_code   = gate_code_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Testbench for gate_identifier: a behavioural gate model answers the DUT
// stimulus; each scenario task drives a run and checks latency, stimulus,
// busy/done timing and the decoded result inline.
module tb_gate_identifier;

    localparam int S = 2;
`ifdef GATE_ID_REPEAT_EN
    localparam int PER = S + 2;
`else
    localparam int PER = S + 1;
`endif
    localparam int LAT = 4 * PER + 1;

    // Gate models: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 constant 1
    localparam int M_AND = 0, M_OR = 1, M_NAND = 2, M_NOR = 3;
    localparam int M_XOR = 4, M_XNOR = 5, M_ONE = 6;

    logic       clk;
    logic       rst;
    logic       start;
    logic       probe_y;
    logic       drv_a;
    logic       drv_b;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_code;
    logic       valid;
    logic       unstable;

    int   gate_model;
    logic flip;
    logic model_out;

    int checks;
    int errors;

    gate_identifier #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .probe_y     (probe_y),
        .drv_a       (drv_a),
        .drv_b       (drv_b),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table),
        .gate_code   (gate_code),
        .valid       (valid),
        .unstable    (unstable)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        model_out = 1'b0;
        case (gate_model)
            M_AND:  model_out = drv_a & drv_b;
            M_OR:   model_out = drv_a | drv_b;
            M_NAND: model_out = ~(drv_a & drv_b);
            M_NOR:  model_out = ~(drv_a | drv_b);
            M_XOR:  model_out = drv_a ^ drv_b;
            M_XNOR: model_out = ~(drv_a ^ drv_b);
            M_ONE:  model_out = 1'b1;
            default: model_out = 1'b0;
        endcase
    end
    assign probe_y = model_out ^ flip;

    // Start a run and follow it cycle by cycle. Cycle 1 is the first cycle
    // after the start-accept edge. Extra start pulses at s1/s2/s3 must be
    // ignored; flip_cycle inverts probe_y for that one cycle.
    task automatic run_gate(input int model, input int s1, input int s2,
                            input int s3, input int flip_cycle,
                            input logic [3:0] exp_tt, input logic [2:0] exp_code,
                            input logic exp_valid, input logic exp_unstable,
                            input string name);
        int done_cycle;
        int done_cnt;
        logic [3:0] prev_tt;
        logic [1:0] exp_drv;
        logic       exp_busy;
        gate_model = model;
        prev_tt    = truth_table;
        done_cycle = 0;
        done_cnt   = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAT + 2; c++) begin
            start = (c == s1) || (c == s2) || (c == s3);
            flip  = (c == flip_cycle);
            #1;
            if (done) begin
                done_cnt++;
                if (done_cycle == 0) done_cycle = c;
            end
            exp_drv  = (c < LAT) ? 2'((c - 1) / PER) : 2'd0;
            exp_busy = (c <= LAT);
            checks++;
            if ({drv_a, drv_b} !== exp_drv) begin
                errors++;
                $display("FAIL %s drv cycle %0d: got %b want %b", name, c, {drv_a, drv_b}, exp_drv);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, exp_busy);
            end
            if (c <= LAT) begin
                checks++;
                if (truth_table !== prev_tt) begin
                    errors++;
                    $display("FAIL %s hold cycle %0d: got %b want %b", name, c, truth_table, prev_tt);
                end
            end
            if (c == LAT + 1) begin
                checks++;
                if (truth_table !== exp_tt) begin
                    errors++;
                    $display("FAIL %s truth_table: got %b want %b", name, truth_table, exp_tt);
                end
                checks++;
                if (gate_code !== exp_code) begin
                    errors++;
                    $display("FAIL %s gate_code: got %0d want %0d", name, gate_code, exp_code);
                end
                checks++;
                if (valid !== exp_valid) begin
                    errors++;
                    $display("FAIL %s valid: got %b want %b", name, valid, exp_valid);
                end
                checks++;
                if (unstable !== exp_unstable) begin
                    errors++;
                    $display("FAIL %s unstable: got %b want %b", name, unstable, exp_unstable);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        flip  = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (done_cycle != LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, done_cycle, LAT);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({busy, done, drv_a, drv_b} !== 4'b0000) begin
            errors++;
            $display("FAIL %s busy/done/drv: got %b want 0000", name, {busy, done, drv_a, drv_b});
        end
        checks++;
        if (truth_table !== 4'b0000) begin
            errors++;
            $display("FAIL %s truth_table: got %b want 0000", name, truth_table);
        end
        checks++;
        if ({gate_code, valid, unstable} !== {3'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s code/valid/unstable: got %0d/%b/%b want 7/0/0", name, gate_code, valid, unstable);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;  // reset must win over a simultaneous start
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_values("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_override busy: got %b want 0", busy);
        end
    endtask

    task automatic test_gates();
        run_gate(M_XOR,  0, 0, 0, 0, 4'b0110, 3'd4, 1'b1, 1'b0, "xor");
        run_gate(M_AND,  0, 0, 0, 0, 4'b1000, 3'd0, 1'b1, 1'b0, "and");
        run_gate(M_OR,   0, 0, 0, 0, 4'b1110, 3'd1, 1'b1, 1'b0, "or");
        run_gate(M_NAND, 0, 0, 0, 0, 4'b0111, 3'd2, 1'b1, 1'b0, "nand");
        run_gate(M_NOR,  0, 0, 0, 0, 4'b0001, 3'd3, 1'b1, 1'b0, "nor");
        run_gate(M_XNOR, 0, 0, 0, 0, 4'b1001, 3'd5, 1'b1, 1'b0, "xnor");
    endtask

    task automatic test_unknown();
        run_gate(M_ONE, 0, 0, 0, 0, 4'b1111, 3'd7, 1'b0, 1'b0, "const1");
    endtask

    task automatic test_back_to_back();
        // Restart attempts mid-run and in the DONE cycle are ignored.
        run_gate(M_XOR, 3, 12, LAT, 0, 4'b0110, 3'd4, 1'b1, 1'b0, "restart");
    endtask

    task automatic test_reset_mid_run();
        int done_cnt;
        done_cnt   = 0;
        gate_model = M_AND;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        rst = 1'b1;  // cycle 6
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("midrun_reset");
        for (int c = 0; c < LAT + 5; c++) begin
            if (done || busy) done_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d activity cycles want 0", done_cnt);
        end
        run_gate(M_AND, 0, 0, 0, 0, 4'b1000, 3'd0, 1'b1, 1'b0, "and_after_reset");
    endtask

`ifdef GATE_ID_REPEAT_EN
    task automatic test_unstable();
        // Vector 10 occupies cycles 2*PER+1 .. 3*PER; its samples are the
        // last two of those. Invert the second one.
        run_gate(M_OR, 0, 0, 0, 3 * PER, 4'b1010, 3'd7, 1'b0, 1'b1, "unstable_or");
        run_gate(M_OR, 0, 0, 0, 0, 4'b1110, 3'd1, 1'b1, 1'b0, "stable_or");
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        start      = 1'b0;
        flip       = 1'b0;
        gate_model = M_AND;
        test_reset();
        test_gates();
        test_unknown();
        test_back_to_back();
        test_reset_mid_run();
`ifdef GATE_ID_REPEAT_EN
        test_unstable();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
